regfile_write_arbiter: RTL

//   Shares the register file's single write port between two requesters: ALU writeback and memory load.
//   - Requests are accepted with a Req/Gnt handshake.
//   - Conflicts are resolved round-robin.
//   - The granted write is presented to the register file as a registered WriteEn/WriteRegNum/RegData triple.
//   - A read bypass returns the in-flight write value on either read port.
//   - The block sits between the execute/load stages and the register file.

---
 rtl/regfile_write_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU writeback and memory
// load, with a registered write triple, read bypass and a saturating accepted-write counter.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              AluReq,
  input  logic [ADDR_W-1:0] AluRegNum,
  input  logic [DATA_W-1:0] AluData,
  output logic              AluGnt,
  input  logic              MemReq,
  input  logic [ADDR_W-1:0] MemRegNum,
  input  logic [DATA_W-1:0] MemData,
  output logic              MemGnt,
  output logic              WriteEn,
  output logic [ADDR_W-1:0] WriteRegNum,
  output logic [DATA_W-1:0] RegData,
  input  logic [ADDR_W-1:0] ReadRegNum1,
  input  logic [ADDR_W-1:0] ReadRegNum2,
  input  logic [DATA_W-1:0] ReadOut1,
  input  logic [DATA_W-1:0] ReadOut2,
  output logic [DATA_W-1:0] RdData1,
  output logic [DATA_W-1:0] RdData2,
  output logic [CNT_W-1:0]  WriteCount
);

  localparam logic PriAlu = 1'b0;
  localparam logic PriMem = 1'b1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic              pri_q;
  logic              alu_elig, mem_elig;
  logic              alu_win, mem_win, any_win;
  logic [ADDR_W-1:0] win_reg;
  logic [DATA_W-1:0] win_data;

  // A side that was granted last cycle sits out one cycle, so the same request is never
  // accepted twice and the other side gets a chance.
  always_comb begin
    alu_elig = AluReq && !AluGnt;
    mem_elig = MemReq && !MemGnt;
    alu_win  = alu_elig && (!mem_elig || (pri_q == PriAlu));
    mem_win  = mem_elig && !alu_win;
    any_win  = alu_win || mem_win;
  end

  // Select only from the winning side so X on an idle requester never reaches the outputs.
  always_comb begin
    win_reg  = '0;
    win_data = '0;
    if (alu_win) begin
      win_reg  = AluRegNum;
      win_data = AluData;
    end else if (mem_win) begin
      win_reg  = MemRegNum;
      win_data = MemData;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pri_q       <= PriAlu;
      AluGnt      <= 1'b0;
      MemGnt      <= 1'b0;
      WriteEn     <= 1'b0;
      WriteRegNum <= '0;
      RegData     <= '0;
      WriteCount  <= '0;
    end else begin
      AluGnt  <= alu_win;
      MemGnt  <= mem_win;
      WriteEn <= any_win && (win_reg != '0);
      if (alu_win) begin
        pri_q <= PriMem;
      end else if (mem_win) begin
        pri_q <= PriAlu;
      end
      if (any_win) begin
        WriteRegNum <= win_reg;
        RegData     <= win_data;
        if (WriteCount != CntMax) begin
          WriteCount <= WriteCount + 1'b1;
        end
      end
    end
  end

  always_comb begin
    RdData1 = ReadOut1;
    RdData2 = ReadOut2;
    if (WriteEn && (WriteRegNum == ReadRegNum1) && (ReadRegNum1 != '0)) begin
      RdData1 = RegData;
    end
    if (WriteEn && (WriteRegNum == ReadRegNum2) && (ReadRegNum2 != '0)) begin
      RdData2 = RegData;
    end
  end

endmodule
